riscv_mc_controller: RTL and testbench
======================================

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 i_CLK  input  1  single clock; all state changes on rising edge.
REQ-003 i_Reset  input  1  reset, asynchronous, active-low.
REQ-004 i_Op  input  7  instruction opcode, Instr[6:0] from the instruction register.
REQ-005 i_Funct3  input  3  Instr[14:12].
REQ-006 i_Funct7b5  input  1  Instr[30].
REQ-007 i_Zero  input  1  ALU zero flag.
REQ-008 o_PCWrite  output  1  PC register enable.
REQ-009 o_AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 o_MemWrite  output  1  data memory write enable.
REQ-011 o_IRWrite  output  1  instruction register / OldPC enable.
REQ-012 o_RegWrite  output  1  register file write enable.
REQ-013 o_ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 o_ALUSrcA  output  2  SrcA select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-015 o_ALUSrcB  output  2  SrcB select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
REQ-016 o_ALUControl  output  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-017 o_ImmSrc  output  2  extend type: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 o_Illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-019 o_Retire  output  1  one-cycle pulse in the last cycle of each legal instruction.

Function
REQ-020 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ and JAL; o_PCWrite alone depends on i_Zero.
REQ-021 The FSM SHALL make these transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw (0000011) or sw (0100011).
- DECODE->EXECR for R-type (0110011).
- DECODE->EXECI for I-type ALU (0010011).
- DECODE->BEQ for beq (1100011).
- DECODE->JAL for jal (1101111).
- DECODE->FETCH for any other opcode, with o_Illegal=1 in that DECODE cycle.
- MEMADR->MEMREAD for lw, MEMADR->MEMWRITE for sw.
- MEMREAD->MEMWB.
- EXECR, EXECI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-022 Per-state outputs; any output not listed SHALL be 0 (ALUControl = add):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: ResultSrc=00, AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl decoded.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl decoded.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00, PCWrite=i_Zero.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1.
REQ-023 The ALU decode in EXECR and EXECI SHALL be:
- funct3 000: sub if i_Op[5] & i_Funct7b5, else add.
- funct3 010: slt.
- funct3 110: or.
- funct3 111: and.
- any other funct3: add.
REQ-024 o_ImmSrc SHALL be a combinational function of i_Op in every state: sw = 01, beq = 10, jal = 11, else 00.
REQ-025 o_Retire SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB and BEQ.
REQ-026 Latency in cycles SHALL be: lw = 5, sw = 4, R-type = 4, I-type = 4, jal = 4, beq = 3, illegal = 2.
REQ-027 i_Op, i_Funct3 and i_Funct7b5 SHALL be sampled only after FETCH; their value during FETCH is don't-care.

Reset
REQ-028 When i_Reset=0, the state SHALL go to FETCH immediately, independent of i_CLK.
REQ-029 While i_Reset=0, o_PCWrite, o_IRWrite, o_MemWrite, o_RegWrite, o_Illegal and o_Retire SHALL be forced to 0; the other outputs SHALL take their FETCH values.
REQ-030 An instruction in progress when reset asserts SHALL be abandoned with no further write-enable pulse.
REQ-031 The first rising edge after reset deassertion SHALL execute FETCH.

Verification
REQ-032 Reset release, then lw (i_Op=0000011) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only; Retire pulses once.
REQ-033 sw (0100011) -> MemWrite=1 and AdrSrc=1 in cycle 4, RegWrite never 1, o_ImmSrc=01 throughout.
REQ-034 R-type sub (funct3=000, Funct7b5=1) -> ALUControl=001 in EXECR; the same with i_Op=0010011 -> ALUControl=000.
REQ-035 beq with i_Zero=1 -> PCWrite=1 in cycle 3; with i_Zero=0 -> PCWrite=0; both return to FETCH at cycle 4.
REQ-036 i_Op=1111111 -> o_Illegal=1 in DECODE, FETCH next cycle, no RegWrite/MemWrite; jal -> PCWrite=1 in JAL, RegWrite=1 in ALUWB.
REQ-037 i_Reset=0 asserted in MEMREAD -> all enables 0 immediately; after release, FETCH with IRWrite=1 and no MEMWB.

Source files
------------

// File: rtl/riscv_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mc_controller
//  Description : Control FSM for a multicycle RV32 subset datapath
//                (lw, sw, R-type, I-type ALU, beq, jal). Moore outputs
//                except PCWrite in BEQ, which follows the ALU zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_mc_controller (
    input  logic       i_CLK,
    input  logic       i_Reset,
    input  logic [6:0] i_Op,
    input  logic [2:0] i_Funct3,
    input  logic       i_Funct7b5,
    input  logic       i_Zero,
    output logic       o_PCWrite,
    output logic       o_AdrSrc,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [2:0] o_ALUControl,
    output logic [1:0] o_ImmSrc,
    output logic       o_Illegal,
    output logic       o_Retire
);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_alu_decoded;

    // State register; reset returns to FETCH without waiting for a clock
    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    // ALU operation for register/immediate arithmetic; only R-type can subtract
    always_comb begin
        w_alu_decoded = c_ALU_ADD;
        case (i_Funct3)
            3'b000:  w_alu_decoded = (i_Op[5] && i_Funct7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_decoded = c_ALU_SLT;
            3'b110:  w_alu_decoded = c_ALU_OR;
            3'b111:  w_alu_decoded = c_ALU_AND;
            default: w_alu_decoded = c_ALU_ADD;
        endcase
    end

    // Immediate format depends only on the opcode, in every state
    always_comb begin
        case (i_Op)
            c_OP_SW:  o_ImmSrc = 2'b01;
            c_OP_BEQ: o_ImmSrc = 2'b10;
            c_OP_JAL: o_ImmSrc = 2'b11;
            default:  o_ImmSrc = 2'b00;
        endcase
    end

    // Next state and per-state outputs; enables are masked while in reset
    always_comb begin
        w_next       = S_FETCH;
        o_PCWrite    = 1'b0;
        o_AdrSrc     = 1'b0;
        o_MemWrite   = 1'b0;
        o_IRWrite    = 1'b0;
        o_RegWrite   = 1'b0;
        o_ResultSrc  = 2'b00;
        o_ALUSrcA    = 2'b00;
        o_ALUSrcB    = 2'b00;
        o_ALUControl = c_ALU_ADD;
        o_Illegal    = 1'b0;
        o_Retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                o_IRWrite   = 1'b1;
                o_ALUSrcB   = 2'b10;
                o_ResultSrc = 2'b10;
                o_PCWrite   = 1'b1;
            end
            S_DECODE: begin
                o_ALUSrcA = 2'b01;
                o_ALUSrcB = 2'b01;
                case (i_Op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_R:           w_next = S_EXECR;
                    c_OP_I:           w_next = S_EXECI;
                    c_OP_BEQ:         w_next = S_BEQ;
                    c_OP_JAL:         w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        o_Illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_next    = (i_Op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
                o_ALUSrcA = 2'b10;
                o_ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                w_next   = S_MEMWB;
                o_AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                o_ResultSrc = 2'b01;
                o_RegWrite  = 1'b1;
                o_Retire    = 1'b1;
            end
            S_MEMWRITE: begin
                o_AdrSrc   = 1'b1;
                o_MemWrite = 1'b1;
                o_Retire   = 1'b1;
            end
            S_EXECR: begin
                w_next       = S_ALUWB;
                o_ALUSrcA    = 2'b10;
                o_ALUControl = w_alu_decoded;
            end
            S_EXECI: begin
                w_next       = S_ALUWB;
                o_ALUSrcA    = 2'b10;
                o_ALUSrcB    = 2'b01;
                o_ALUControl = w_alu_decoded;
            end
            S_ALUWB: begin
                o_RegWrite = 1'b1;
                o_Retire   = 1'b1;
            end
            S_BEQ: begin
                o_ALUSrcA    = 2'b10;
                o_ALUControl = c_ALU_SUB;
                o_PCWrite    = i_Zero;
                o_Retire     = 1'b1;
            end
            S_JAL: begin
                w_next    = S_ALUWB;
                o_ALUSrcA = 2'b01;
                o_ALUSrcB = 2'b10;
                o_PCWrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
        if (!i_Reset) begin
            o_PCWrite  = 1'b0;
            o_IRWrite  = 1'b0;
            o_MemWrite = 1'b0;
            o_RegWrite = 1'b0;
            o_Illegal  = 1'b0;
            o_Retire   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_mc_controller
//  Description : Scoreboard bench for riscv_mc_controller. A stimulus process
//                issues instructions and queues the expected output vector of
//                every cycle; a monitor pops and compares on each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mc_controller;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] f3 = 3'd0;
    logic       f7 = 1'b0;
    logic       zero = 1'b0;

    logic       pcw, adr, mw, irw, rw, ill, ret;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;

    logic [17:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    riscv_mc_controller dut (
        .i_CLK        (clk),
        .i_Reset      (rst_n),
        .i_Op         (op),
        .i_Funct3     (f3),
        .i_Funct7b5   (f7),
        .i_Zero       (zero),
        .o_PCWrite    (pcw),
        .o_AdrSrc     (adr),
        .o_MemWrite   (mw),
        .o_IRWrite    (irw),
        .o_RegWrite   (rw),
        .o_ResultSrc  (rs),
        .o_ALUSrcA    (sa),
        .o_ALUSrcB    (sb),
        .o_ALUControl (alu),
        .o_ImmSrc     (imm),
        .o_Illegal    (ill),
        .o_Retire     (ret)
    );

    always #5 clk = ~clk;

    // Output vector layout shared by model and monitor
    function automatic logic [17:0] pack(logic p, logic a, logic m, logic i, logic r,
                                         logic [1:0] res, logic [1:0] srca, logic [1:0] srcb,
                                         logic [2:0] ctl, logic [1:0] im, logic il, logic rt);
        return {p, a, m, i, r, res, srca, srcb, ctl, im, il, rt};
    endfunction

    function automatic logic [6:0] opcode_of(int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            K_JAL:   return 7'b1101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic bit is_legal(logic [6:0] o);
        for (int k = K_LW; k <= K_JAL; k++)
            if (o == opcode_of(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int cycles_of(int kind);
        case (kind)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] o);
        if (o == opcode_of(K_SW))  return 2'b01;
        if (o == opcode_of(K_BEQ)) return 2'b10;
        if (o == opcode_of(K_JAL)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] fn3, logic fn7);
        case (fn3)
            3'd0:    return (o == opcode_of(K_R) && fn7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] reset_vec(logic [6:0] o);
        return pack(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(o), 0, 0);
    endfunction

    // Expected outputs of cycle k (0 = fetch) of an instruction of the given kind
    function automatic logic [17:0] model(int kind, int k, logic [6:0] o, logic [2:0] fn3,
                                          logic fn7, logic z);
        logic [1:0] im;
        im = imm_of(o);
        if (k == 0) return pack(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0, 0);
        if (k == 1) return pack(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, im, kind == K_ILL, 0);
        case (kind)
            K_LW, K_SW: begin
                if (k == 2) return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0, 0);
                if (kind == K_SW) return pack(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 1);
                if (k == 3) return pack(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 0);
                return pack(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, im, 0, 1);
            end
            K_R, K_I: begin
                if (k == 2) return pack(0, 0, 0, 0, 0, 2'b00, 2'b10, (kind == K_I) ? 2'b01 : 2'b00,
                                        alu_of(o, fn3, fn7), im, 0, 0);
                return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 1);
            end
            K_BEQ: return pack(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, im, 0, 1);
            K_JAL: begin
                if (k == 2) return pack(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, im, 0, 0);
                return pack(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, im, 0, 1);
            end
            default: return 18'h3ffff;
        endcase
    endfunction

    // Issue one instruction; abort_at >= 0 asserts reset during that cycle
    task automatic run_instr(input int kind, input logic [6:0] o, input logic [2:0] fn3,
                             input logic fn7, input int zmode, input int abort_at);
        for (int k = 0; k < cycles_of(kind); k++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            op    = o;
            f3    = (k == 0) ? 3'($urandom) : fn3;
            f7    = (k == 0) ? 1'($urandom) : fn7;
            zero  = (zmode >= 0) ? 1'(zmode) : 1'($urandom);
            if (k == abort_at) begin
                #1 rst_n = 1'b0;
                exp_q.push_back(reset_vec(op));
                @(posedge clk);
                #1;
                exp_q.push_back(reset_vec(op));
                return;
            end
            exp_q.push_back(model(kind, k, op, f3, f7, zero));
        end
    endtask

    task automatic run_random(input int kind);
        logic [6:0] o;
        o = opcode_of(kind);
        if (kind == K_ILL) begin
            o = 7'($urandom);
            while (is_legal(o)) o = 7'($urandom);
        end
        run_instr(kind, o, 3'($urandom), 1'($urandom), -1, -1);
    endtask

    // Monitor: compare every sampled cycle against the oldest queued expectation
    always @(negedge clk) begin
        logic [17:0] got, want;
        cyc++;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill, ret};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs cyc=%0d got=%05h want=%05h", cyc, got, want);
            end
        end
    end

    initial begin
        repeat (2) begin
            @(posedge clk);
            #1;
            exp_q.push_back(reset_vec(op));
        end
        // Directed: lw, sw, R sub, I addi with funct7b5 set, beq both ways, illegal, jal
        run_instr(K_LW,  opcode_of(K_LW),  3'd2, 1'b0, -1, -1);
        run_instr(K_SW,  opcode_of(K_SW),  3'd2, 1'b0, -1, -1);
        run_instr(K_R,   opcode_of(K_R),   3'd0, 1'b1, -1, -1);
        run_instr(K_I,   opcode_of(K_I),   3'd0, 1'b1, -1, -1);
        run_instr(K_BEQ, opcode_of(K_BEQ), 3'd0, 1'b0,  1, -1);
        run_instr(K_BEQ, opcode_of(K_BEQ), 3'd0, 1'b0,  0, -1);
        run_instr(K_ILL, 7'b1111111,       3'd0, 1'b0, -1, -1);
        run_instr(K_JAL, opcode_of(K_JAL), 3'd0, 1'b0, -1, -1);
        // Reset in MEMREAD abandons the load; next instruction starts at FETCH
        run_instr(K_LW,  opcode_of(K_LW),  3'd2, 1'b0, -1, 3);
        run_instr(K_R,   opcode_of(K_R),   3'd7, 1'b0, -1, -1);
        // Random mix, including occasional mid-instruction resets
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = int'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0)
                run_instr(kind, opcode_of(kind), 3'($urandom), 1'($urandom), -1,
                          int'($urandom_range(0, cycles_of(kind) - 1)));
            else
                run_random(kind);
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
